// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, bit positions and TX state type for the APB UART
package uart_apb_pkg;

  localparam int REG_TXDATA  = 0;
  localparam int REG_RXDATA  = 1;
  localparam int REG_CLK_DIV = 2;
  localparam int REG_STATUS  = 3;
  localparam int REG_CTRL    = 4;
  localparam int REG_IRQ_EN  = 5;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_PARITY   = 5;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;
  localparam int CTRL_WM_LSB   = 8;

  localparam int IRQ_TX_EMPTY = 0;
  localparam int IRQ_RX_LEVEL = 1;
  localparam int IRQ_OVERRUN  = 2;
  localparam int IRQ_PARITY   = 3;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // A divider of zero would never advance; treat it as one clock per bit.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with flush, level count and combinational head
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - serial receiver, mid-bit sampling, flags even-parity mismatch
module uart_rx
  import uart_apb_pkg::*;
(
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [31:0] clk_div,
  input  logic        rx_i,
  output logic        rx_valid_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_err_o
);
  logic [1:0]  sync;
  logic        rx_s;
  logic        busy;
  logic [3:0]  bit_idx;
  logic [31:0] cnt;
  logic [8:0]  shift;
  logic [31:0] div;
  logic [31:0] half;

  assign rx_s = sync[1];
  assign div  = eff_div(clk_div);
  // Synchroniser and edge detection already cost cycles, so aim one short of half a bit.
  assign half = ((div >> 1) == 32'd0) ? 32'd0 : (div >> 1) - 32'd1;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sync       <= 2'b11;
      busy       <= 1'b0;
      bit_idx    <= '0;
      cnt        <= '0;
      shift      <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_err_o   <= 1'b0;
    end else begin
      sync       <= {sync[0], rx_i};
      rx_valid_o <= 1'b0;
      if (!busy) begin
        if (!rx_s) begin
          busy    <= 1'b1;
          bit_idx <= '0;
          cnt     <= half;
        end
      end else if (cnt != 32'd0) begin
        cnt <= cnt - 32'd1;
      end else begin
        cnt     <= div - 32'd1;
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd0) begin
          if (rx_s) busy <= 1'b0;
        end else if (bit_idx == 4'd10) begin
          busy       <= 1'b0;
          rx_valid_o <= 1'b1;
          rx_data_o  <= shift[7:0];
          rx_err_o   <= ^shift;
        end else begin
          shift <= {rx_s, shift[8:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial transmitter: start, 8 data LSB first, even parity, stop
module uart_tx
  import uart_apb_pkg::*;
(
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [31:0] clk_div,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_o,
  output logic        tx_done_o
);
  logic        busy;
  logic [3:0]  bit_idx;
  logic [31:0] cnt;
  logic [10:0] frame;
  logic [31:0] div;
  logic        bit_end;

  assign div       = eff_div(clk_div);
  assign bit_end   = (cnt >= div - 32'd1);
  assign tx_o      = busy ? frame[bit_idx] : 1'b1;
  assign tx_done_o = busy && (bit_idx == 4'd10) && bit_end;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      busy    <= 1'b0;
      bit_idx <= '0;
      cnt     <= '0;
      frame   <= '1;
    end else if (!busy) begin
      if (tx_valid_i) begin
        busy    <= 1'b1;
        bit_idx <= '0;
        cnt     <= '0;
        frame   <= {1'b1, ^tx_data_i, tx_data_i, 1'b0};
      end
    end else if (bit_end) begin
      cnt <= '0;
      if (bit_idx == 4'd10) busy <= 1'b0;
      else                  bit_idx <= bit_idx + 4'd1;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_apb_fifo.sv
// rtl/uart_apb_fifo.sv - APB UART top: register file, TX sequencing, RX capture, sticky errors, IRQ
module uart_apb_fifo
  import uart_apb_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'hFFFF_FFFF,
  parameter int          ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq_o,
  input  logic              rx_i,
  output logic              tx_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            access, wr, rd, bad_idx;
  logic [31:0]     reg_idx;
  logic            unused_addr_bits;
  logic [31:0]     clk_div_q;
  logic            tx_en_q, rx_en_q;
  logic [3:0]      wm_q, wm_eff, irq_en_q;
  logic            ovr_q, perr_q, ovr_set, perr_set, rx_level_hit;
  logic            wr_status;

  logic            tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0]      tx_head;
  logic [CW-1:0]   tx_count;
  logic            rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0]      rx_head;
  logic [CW-1:0]   rx_count;

  logic            tx_valid, tx_done, tx_kill_q;
  logic [7:0]      tx_byte, tx_byte_q;
  logic            rx_valid, rx_err;
  logic [7:0]      rx_data;
  tx_state_e       state_q, state_d;

  assign access           = PSEL && PENABLE;
  assign wr               = access && PWRITE;
  assign rd               = access && !PWRITE;
  assign reg_idx          = 32'(PADDR[ADDR_W-1:2]);
  assign unused_addr_bits = ^PADDR[1:0];
  assign bad_idx          = (reg_idx > REG_IRQ_EN);
  assign PREADY           = access;
  assign PSLVERR          = access && (bad_idx || (wr && reg_idx == REG_TXDATA && tx_full));

  assign wr_status = wr && reg_idx == REG_STATUS;
  assign tx_push   = wr && reg_idx == REG_TXDATA && !tx_full;
  assign rx_pop    = rd && reg_idx == REG_RXDATA && !rx_empty;
  assign tx_flush  = wr && reg_idx == REG_CTRL && PWDATA[CTRL_TX_FLUSH];
  assign rx_flush  = wr && reg_idx == REG_CTRL && PWDATA[CTRL_RX_FLUSH];
  assign rx_push   = rx_valid && rx_en_q;
  assign ovr_set   = rx_push && rx_full && !rx_pop;
  assign perr_set  = rx_push && rx_err;

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (reg_idx)
        REG_RXDATA:  PRDATA = rx_empty ? 32'd0 : {1'b1, 23'd0, rx_head};
        REG_CLK_DIV: PRDATA = clk_div_q;
        REG_STATUS:  PRDATA = {8'd0, 8'(rx_count), 8'(tx_count), 2'b00, perr_q, ovr_q,
                               rx_full, rx_empty, tx_full, tx_empty};
        REG_CTRL:    PRDATA = {20'd0, wm_q, 6'd0, rx_en_q, tx_en_q};
        REG_IRQ_EN:  PRDATA = {28'd0, irq_en_q};
        default:     PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      clk_div_q <= DEFAULT_DIV;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      wm_q      <= '0;
      irq_en_q  <= '0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (wr && reg_idx == REG_CLK_DIV) clk_div_q <= PWDATA;
      if (wr && reg_idx == REG_CTRL) begin
        tx_en_q <= PWDATA[CTRL_TX_EN];
        rx_en_q <= PWDATA[CTRL_RX_EN];
        wm_q    <= PWDATA[CTRL_WM_LSB +: 4];
      end
      if (wr && reg_idx == REG_IRQ_EN) irq_en_q <= PWDATA[3:0];
      // A new error in the same cycle as its clear keeps the flag set.
      ovr_q  <= ovr_set  || (ovr_q  && !(wr_status && PWDATA[ST_OVERRUN]));
      perr_q <= perr_set || (perr_q && !(wr_status && PWDATA[ST_PARITY]));
    end
  end

  assign wm_eff       = (wm_q == 4'd0) ? 4'd1 : wm_q;
  assign rx_level_hit = 8'(rx_count) >= 8'(wm_eff);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= |(irq_en_q & {perr_q, ovr_q, rx_level_hit, tx_empty});
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TX_IDLE;
      tx_byte_q <= '0;
      tx_kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == TX_IDLE) tx_byte_q <= tx_head;
      // The byte on the wire was flushed away; its completion must not pop a newer entry.
      if (state_d == TX_IDLE)                  tx_kill_q <= 1'b0;
      else if (tx_flush && state_q == TX_SEND) tx_kill_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_pop   = 1'b0;
    tx_byte  = tx_byte_q;
    case (state_q)
      TX_IDLE: begin
        tx_byte = tx_head;
        if (tx_en_q && !tx_empty) begin
          tx_valid = 1'b1;
          state_d  = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_valid = 1'b1;
        if (tx_done) begin
          tx_pop  = !tx_kill_q;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst_i), .push(tx_push), .push_data(PWDATA[7:0]), .pop(tx_pop),
    .flush(tx_flush), .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst_i), .push(rx_push), .push_data(rx_data), .pop(rx_pop),
    .flush(rx_flush), .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_tx u_uart_tx (
    .clk(clk), .rstn_i(~rst_i), .clk_div(clk_div_q), .tx_valid_i(tx_valid),
    .tx_data_i(tx_byte), .tx_o(tx_o), .tx_done_o(tx_done)
  );

  uart_rx u_uart_rx (
    .clk(clk), .rstn_i(~rst_i), .clk_div(clk_div_q), .rx_i(rx_i),
    .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_err_o(rx_err)
  );

endmodule

// File: tb/tb_uart_apb_fifo.sv
// tb/tb_uart_apb_fifo.sv - scoreboard bench for the APB UART with queue-based reference model
module tb_uart_apb_fifo;
  localparam int DIV   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq_o;
  logic        rx_i, tx_o;

  always #5 clk = ~clk;

  uart_apb_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_i(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq_o(irq_o), .rx_i(rx_i), .tx_o(tx_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic        err;
    string       name;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit         m_ovr = 0;
  bit         m_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = '0;
    s[0] = (tx_m.size() == 0);
    s[1] = (tx_m.size() == DEPTH);
    s[2] = (rx_m.size() == 0);
    s[3] = (rx_m.size() == DEPTH);
    s[4] = m_ovr;
    s[5] = m_perr;
    s[15:8]  = 8'(tx_m.size());
    s[23:16] = 8'(rx_m.size());
    return s;
  endfunction

  always @(negedge clk) begin
    if (PSEL && PENABLE) begin
      apb_exp_t e;
      if (apb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL apb_unexpected: access at %0t with no expectation, required none", $time);
      end else begin
        e = apb_q.pop_front();
        chk({e.name, " pready"}, 32'(PREADY), 32'd1);
        if (e.is_rd) chk({e.name, " prdata"}, PRDATA, e.data);
        chk({e.name, " pslverr"}, 32'(PSLVERR), 32'(e.err));
      end
    end
  end

  initial begin : tx_mon
    logic [10:0] f;
    logic [7:0]  b;
    bit          ab;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0 && rst === 1'b0) begin
        ab = 0;
        f  = '0;
        for (int c = 1; c <= 2 + 10 * DIV; c++) begin
          @(negedge clk);
          if (rst) ab = 1;
          if (c >= 2 && (c - 2) % DIV == 0) f[(c - 2) / DIV] = tx_o;
        end
        if (!ab) begin
          if (tx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: frame %h, required no frame", f);
          end else begin
            b = tx_exp.pop_front();
            chk("tx_frame", 32'(f), 32'({1'b1, ^b, b, 1'b0}));
          end
        end
      end
    end
  end

  task automatic apb(input bit w, input logic [4:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp, input bit exp_err, input string name);
    apb_exp_t e;
    e.is_rd = !w;
    e.data  = exp;
    e.err   = exp_err;
    e.name  = name;
    apb_q.push_back(e);
    @(posedge clk); #1;
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1;
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic tx_write(input logic [7:0] b, input bit en, input bit track);
    bit full;
    full = (tx_m.size() == DEPTH);
    if (!full) begin
      if (en) begin
        if (track) tx_exp.push_back(b);
      end else begin
        tx_m.push_back(b);
      end
    end
    apb(1, 5'h00, {24'd0, b}, 32'd0, full, "txdata");
  endtask

  task automatic rd_rx();
    logic [31:0] exp;
    exp = 32'd0;
    if (rx_m.size() != 0) exp = {1'b1, 23'd0, rx_m.pop_front()};
    apb(0, 5'h04, 32'd0, exp, 0, "rxdata");
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_i = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (rx_m.size() < DEPTH) rx_m.push_back(b);
    else                     m_ovr = 1;
    if (bad_par) m_perr = 1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (tx_exp.size() != 0) begin
      bad++;
      $display("FAIL tx_drain: %0d frames pending, required 0", tx_exp.size());
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] r;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    rx_i = 1'b1;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_o", 32'(tx_o), 32'd1);
    chk("rst pready", 32'(PREADY), 32'd0);
    chk("rst prdata", PRDATA, 32'd0);
    chk("rst pslverr", 32'(PSLVERR), 32'd0);
    chk("rst irq", 32'(irq_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    apb(0, 5'h0C, 0, status_m(), 0, "status_reset");
    apb(0, 5'h08, 0, 32'hFFFF_FFFF, 0, "clkdiv_reset");
    apb(0, 5'h10, 0, 32'd0, 0, "ctrl_reset");
    apb(0, 5'h14, 0, 32'd0, 0, "irqen_reset");
    apb(1, 5'h08, DIV, 0, 0, "clkdiv_wr");
    apb(0, 5'h08, 0, DIV, 0, "clkdiv_rd");
    apb(0, 5'h18, 0, 32'd0, 1, "bad_idx_rd");
    apb(1, 5'h1C, 32'hFF, 0, 1, "bad_idx_wr");

    apb(1, 5'h10, 32'h1, 0, 0, "ctrl_txen");
    tx_write(8'h41, 1, 1);
    tx_write(8'h42, 1, 1);
    tx_write(8'h43, 1, 1);
    for (int i = 0; i < 5; i++) tx_write(8'($urandom_range(0, 255)), 1, 1);
    wait_drain(3000);
    apb(0, 5'h0C, 0, status_m(), 0, "status_tx_done");

    apb(1, 5'h10, 32'h0, 0, 0, "ctrl_txdis");
    for (int i = 0; i < DEPTH + 1; i++) tx_write(8'($urandom_range(0, 255)), 0, 0);
    apb(0, 5'h0C, 0, status_m(), 0, "status_tx_full");
    while (tx_m.size() != 0) tx_exp.push_back(tx_m.pop_front());
    apb(1, 5'h10, 32'h1, 0, 0, "ctrl_txen2");
    wait_drain(3000);
    apb(0, 5'h0C, 0, status_m(), 0, "status_tx_drained");

    apb(1, 5'h10, 32'h0, 0, 0, "ctrl_txdis2");
    for (int i = 0; i < 5; i++) tx_write(8'($urandom_range(0, 255)), 0, 0);
    apb(0, 5'h0C, 0, status_m(), 0, "status_tx_5");
    apb(1, 5'h10, 32'h4, 0, 0, "ctrl_txflush");
    tx_m.delete();
    apb(0, 5'h0C, 0, status_m(), 0, "status_tx_flushed");

    apb(1, 5'h10, 32'h2, 0, 0, "ctrl_rxen");
    for (int i = 0; i < DEPTH + 2; i++) rx_frame(8'($urandom_range(0, 255)), 0);
    apb(0, 5'h0C, 0, status_m(), 0, "status_rx_overrun");
    for (int i = 0; i < DEPTH + 1; i++) rd_rx();
    apb(0, 5'h0C, 0, status_m(), 0, "status_rx_read");
    apb(1, 5'h0C, 32'h10, 0, 0, "status_w1c_ovr");
    m_ovr = 0;
    apb(0, 5'h0C, 0, status_m(), 0, "status_ovr_clr");

    apb(1, 5'h10, 32'h402, 0, 0, "ctrl_wm4");
    apb(1, 5'h14, 32'h2, 0, 0, "irqen_level");
    for (int i = 0; i < 3; i++) rx_frame(8'($urandom_range(0, 255)), 0);
    chk("irq_below_wm", 32'(irq_o), 32'd0);
    rx_frame(8'($urandom_range(0, 255)), 0);
    chk("irq_at_wm", 32'(irq_o), 32'd1);
    rd_rx();
    repeat (2) @(posedge clk);
    #1;
    chk("irq_after_pop", 32'(irq_o), 32'd0);
    for (int i = 0; i < 3; i++) rd_rx();

    apb(1, 5'h14, 32'h8, 0, 0, "irqen_parity");
    r = 8'($urandom_range(0, 255));
    rx_frame(r, 1);
    chk("irq_parity", 32'(irq_o), 32'd1);
    apb(0, 5'h0C, 0, status_m(), 0, "status_parity");
    apb(1, 5'h0C, 32'h20, 0, 0, "status_w1c_par");
    m_perr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("irq_parity_clr", 32'(irq_o), 32'd0);
    apb(0, 5'h0C, 0, status_m(), 0, "status_par_clr");
    rd_rx();

    apb(1, 5'h10, 32'h1, 0, 0, "ctrl_txen3");
    tx_write(8'($urandom_range(0, 255)), 1, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx tx_o", 32'(tx_o), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_m.delete();
    rx_m.delete();
    m_ovr  = 0;
    m_perr = 0;
    @(posedge clk); #1;
    apb(0, 5'h0C, 0, status_m(), 0, "status_after_rst");
    apb(0, 5'h08, 0, 32'hFFFF_FFFF, 0, "clkdiv_after_rst");
    repeat (60) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
